uart_alu_framer: RTL and testbench
==================================

UART_ALU_FRAMER -- requirements
Module: uart_alu_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter OP_W, default 6, meaning opcode width in bits; legal values are 1 to 8.
REQ-003 SHALL have parameter DELIM, default 8'h20, meaning the operand-terminating byte value.
REQ-004 SHALL have parameter TIMEOUT, default 1000, meaning the inter-byte timeout in clk cycles; legal values are 2 or more.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port d_in, input, 8 bits: received byte, valid when rx_done is high.
REQ-008 SHALL have port rx_done, input, 1 bit: receiver byte-ready level, which may be held high for multiple cycles.
REQ-009 SHALL have port tx_done, input, 1 bit: transmitter one-cycle pulse marking byte-complete.
REQ-010 SHALL have port d_out_ALU, input, DATA_W bits: combinational ALU result.
REQ-011 SHALL have port d_out, output, 8 bits: byte to transmit.
REQ-012 SHALL have port tx_start, output, 1 bit: one-cycle transmit request.
REQ-013 SHALL have port A, output, DATA_W bits: committed operand A.
REQ-014 SHALL have port B, output, DATA_W bits: committed operand B.
REQ-015 SHALL have port opcode, output, OP_W bits: committed opcode.
REQ-016 SHALL have port op_valid, output, 1 bit: one-cycle pulse when A, B and opcode are committed.
REQ-017 SHALL have port err, output, 1 bit: one-cycle pulse on timeout or overrun.

Function
REQ-018 SHALL define a byte event as a rising edge of rx_done (rx_done high in this cycle, low in the previous registered cycle); a held level SHALL count once.
REQ-019 SHALL implement states RX_A, RX_OP, RX_B, COMMIT, CAPTURE, TX_SEND and TX_WAIT.
REQ-020 In RX_A, a byte event with d_in != DELIM SHALL shift it into accumulator accA as {accA[DATA_W-9:0], d_in}; d_in == DELIM SHALL go to RX_OP.
REQ-021 In RX_OP, any byte event SHALL store d_in[OP_W-1:0] into accOp and go to RX_B; DELIM is accepted as an opcode value here.
REQ-022 In RX_B, byte events SHALL shift into accB in the same way as accA; DELIM SHALL go to COMMIT.
REQ-023 More than DATA_W/8 operand bytes SHALL discard the oldest bytes, keeping the last DATA_W/8; an empty operand (DELIM first) SHALL yield 0.
REQ-024 In COMMIT, the block SHALL load A<=accA, B<=accB and opcode<=accOp, pulse op_valid for one cycle, clear the accumulators, and go to CAPTURE.
REQ-025 In CAPTURE, one cycle later, the block SHALL latch d_out_ALU into the result shift register, set the byte index to DATA_W/8-1, and go to TX_SEND.
REQ-026 In TX_SEND, the block SHALL drive d_out with result byte[index], MSB byte first, and pulse tx_start for one cycle, then go to TX_WAIT.
REQ-027 In TX_WAIT, on tx_done, index 0 SHALL go to RX_A and any other index SHALL decrement the index and go to TX_SEND.
REQ-028 d_out SHALL remain stable from the tx_start cycle until tx_done.
REQ-029 A, B and opcode SHALL change only in COMMIT, and SHALL otherwise hold through reception of the next frame.
REQ-030 The timeout counter SHALL run in RX_OP, in RX_B, and in RX_A when at least one byte has been received in the frame; it SHALL clear on each byte event.
REQ-031 On reaching TIMEOUT, the block SHALL pulse err, clear the accumulators, and go to RX_A, leaving A, B and opcode unchanged.
REQ-032 A byte event during COMMIT, CAPTURE, TX_SEND or TX_WAIT SHALL pulse err (overrun), discard the byte, and leave state unaffected.
REQ-033 If a timeout and a byte event occur in the same cycle, the byte event SHALL win and the counter SHALL clear with no err pulse.
REQ-034 tx_done outside TX_WAIT SHALL be ignored.

Reset
REQ-035 While reset is high at a clk edge, the block SHALL enter RX_A with A=0, B=0, opcode=0, d_out=0, tx_start=0, op_valid=0, err=0, the accumulators, counter and index at 0, and the rx_done history register at 0.
REQ-036 Reset asserted mid-frame or mid-transmission SHALL abort the frame or transmission immediately, with no further tx_start pulses.
REQ-037 If rx_done is high when reset deasserts, it SHALL NOT produce a byte event until it has gone low and then high again.

Verification
REQ-038 With defaults, the byte stream 05,04,20,2B,07,20 (each rx_done held 10 cycles, 10 cycles apart) SHALL produce A=0x00000504, opcode=0x2B, B=0x00000007, and a single op_valid pulse.
REQ-039 With d_out_ALU=0x0000050B after commit, the block SHALL produce four tx_start pulses with d_out=00,00,05,0B, each next pulse occurring only after tx_done.
REQ-040 With defaults, the stream 01,02,03,04,05,20 for A SHALL yield A=0x02030405, and the stream 20 SHALL yield A=0.
REQ-041 Byte 05 followed by TIMEOUT idle cycles SHALL produce one err pulse and return to RX_A; the next full frame SHALL commit correctly.
REQ-042 A byte event during TX_WAIT SHALL produce one err pulse while transmission completes unchanged.
REQ-043 Reset asserted during TX_WAIT SHALL return all outputs to 0 on the next edge, with no further tx_start pulses.

Source files
------------

// File: rtl/uart_alu_framer.sv
// rtl/uart_alu_framer.sv - UART byte framer: parses "A DELIM op B DELIM", commits operands, returns ALU result MSB-first
module uart_alu_framer #(
    parameter int          DATA_W  = 32,
    parameter int          OP_W    = 6,
    parameter logic [7:0]  DELIM   = 8'h20,
    parameter int          TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        d_in,
    input  logic              rx_done,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] d_out_ALU,
    output logic [7:0]        d_out,
    output logic              tx_start,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [OP_W-1:0]   opcode,
    output logic              op_valid,
    output logic              err
);
    localparam int NB = DATA_W / 8;

    typedef enum logic [2:0] {
        RX_A, RX_OP, RX_B, COMMIT, CAPTURE, TX_SEND, TX_WAIT
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   acc_a;
    logic [DATA_W-1:0]   acc_b;
    logic [DATA_W-1:0]   res;
    logic [OP_W-1:0]     acc_op;
    logic [31:0]         cnt;
    logic [2:0]          idx;
    logic                rx_prev;
    logic                armed;
    logic                got_byte;

    logic byte_ev;
    logic is_delim;
    logic cnt_run;
    logic timeout_hit;
    logic busy;

    // armed stays low after reset until rx_done is seen low, so a level held across reset is not a byte
    assign byte_ev     = rx_done & ~rx_prev & armed;
    assign is_delim    = (d_in == DELIM);
    assign cnt_run     = (state == RX_OP) || (state == RX_B) || ((state == RX_A) && got_byte);
    assign timeout_hit = cnt_run && !byte_ev && (cnt == 32'(TIMEOUT - 1));
    assign busy        = (state == COMMIT) || (state == CAPTURE) ||
                         (state == TX_SEND) || (state == TX_WAIT);

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] acc,
                                                   input logic [7:0] b);
        logic [DATA_W+7:0] t;
        t = {acc, b};
        return t[DATA_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RX_A;
            acc_a    <= '0;
            acc_b    <= '0;
            acc_op   <= '0;
            res      <= '0;
            cnt      <= '0;
            idx      <= '0;
            rx_prev  <= 1'b0;
            armed    <= 1'b0;
            got_byte <= 1'b0;
            A        <= '0;
            B        <= '0;
            opcode   <= '0;
            d_out    <= '0;
            tx_start <= 1'b0;
            op_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rx_prev  <= rx_done;
            if (!rx_done)
                armed <= 1'b1;
            tx_start <= 1'b0;
            op_valid <= 1'b0;
            err      <= 1'b0;

            if (byte_ev || !cnt_run || timeout_hit)
                cnt <= '0;
            else
                cnt <= cnt + 32'd1;

            if (byte_ev && busy)
                err <= 1'b1;

            if (timeout_hit) begin
                err      <= 1'b1;
                acc_a    <= '0;
                acc_b    <= '0;
                acc_op   <= '0;
                got_byte <= 1'b0;
                state    <= RX_A;
            end else begin
                case (state)
                    RX_A: begin
                        if (byte_ev) begin
                            if (is_delim) begin
                                got_byte <= 1'b0;
                                state    <= RX_OP;
                            end else begin
                                acc_a    <= shift_in(acc_a, d_in);
                                got_byte <= 1'b1;
                            end
                        end
                    end
                    RX_OP: begin
                        if (byte_ev) begin
                            acc_op <= d_in[OP_W-1:0];
                            state  <= RX_B;
                        end
                    end
                    RX_B: begin
                        if (byte_ev) begin
                            if (is_delim)
                                state <= COMMIT;
                            else
                                acc_b <= shift_in(acc_b, d_in);
                        end
                    end
                    COMMIT: begin
                        A        <= acc_a;
                        B        <= acc_b;
                        opcode   <= acc_op;
                        op_valid <= 1'b1;
                        acc_a    <= '0;
                        acc_b    <= '0;
                        acc_op   <= '0;
                        state    <= CAPTURE;
                    end
                    // A/B became visible last cycle, so the external ALU output has settled
                    CAPTURE: begin
                        res   <= d_out_ALU;
                        idx   <= 3'(NB - 1);
                        state <= TX_SEND;
                    end
                    TX_SEND: begin
                        d_out    <= 8'(res >> {idx, 3'b000});
                        tx_start <= 1'b1;
                        state    <= TX_WAIT;
                    end
                    TX_WAIT: begin
                        if (tx_done) begin
                            if (idx == 3'd0) begin
                                state <= RX_A;
                            end else begin
                                idx   <= idx - 3'd1;
                                state <= TX_SEND;
                            end
                        end
                    end
                    default: state <= RX_A;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_alu_framer.sv
// tb/tb_uart_alu_framer.sv - directed bench with a frame-level scoreboard model for uart_alu_framer
module tb_uart_alu_framer;
    logic        clk;
    logic        reset;
    logic [7:0]  d_in;
    logic        rx_done;
    logic        tx_done;
    logic [31:0] alu;
    logic [7:0]  d_out;
    logic        tx_start;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  opcode;
    logic        op_valid;
    logic        err;

    uart_alu_framer dut (
        .clk(clk), .reset(reset), .d_in(d_in), .rx_done(rx_done), .tx_done(tx_done),
        .d_out_ALU(alu), .d_out(d_out), .tx_start(tx_start), .A(A), .B(B),
        .opcode(opcode), .op_valid(op_valid), .err(err)
    );

    // external ALU: addition
    assign alu = A + B;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // frame-level model state
    int          ph = 0;
    logic [31:0] ea = 0, eb = 0;
    logic [5:0]  eo = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [5:0]  qo[$];
    logic [7:0]  qt[$];
    logic [7:0]  tx_log[$];
    logic [31:0] m_a = 0, m_b = 0;
    logic [5:0]  m_o = 0;
    logic [7:0]  cur_byte = 0;
    bit          tx_busy = 0;
    int          err_seen = 0, exp_err = 0, opv_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic [31:0] r;
        case (ph)
            0: if (b == 8'h20) ph = 1; else ea = ea * 256 + 32'(b);
            1: begin eo = b[5:0]; ph = 2; end
            default: begin
                if (b == 8'h20) begin
                    qa.push_back(ea); qb.push_back(eb); qo.push_back(eo);
                    r = ea + eb;
                    for (int i = 3; i >= 0; i--) qt.push_back(8'(r / (32'd1 << (8 * i))));
                    ea = 0; eb = 0; ph = 0;
                end else begin
                    eb = eb * 256 + 32'(b);
                end
            end
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        m_byte(b);
        d_in = b; rx_done = 1'b1;
        repeat (10) step();
        rx_done = 1'b0;
        repeat (10) step();
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((qt.size() != 0 || qa.size() != 0 || tx_busy) && n < 400) begin
            step(); n++;
        end
        if (n >= 400) begin
            errors++;
            $display("FAIL wait_idle timed_out pending_tx=%0d required=0", qt.size());
        end
        repeat (3) step();
    endtask

    task automatic wait_tx_start();
        int n;
        n = 0;
        while (!tx_start && n < 200) begin
            step(); n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_tx_start timed_out tx_start=0 required=1");
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_A"}, A, 0);
        chk({tag, "_B"}, B, 0);
        chk({tag, "_opcode"}, opcode, 0);
        chk({tag, "_d_out"}, d_out, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_op_valid"}, op_valid, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // transmitter stand-in: tx_done pulse a few cycles after each tx_start
    initial begin
        tx_done = 1'b0;
        forever begin
            step();
            if (tx_start && !reset) begin
                repeat (4) step();
                tx_done = 1'b1;
                step();
                tx_done = 1'b0;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        if (reset) begin
            m_a = 0; m_b = 0; m_o = 0; tx_busy = 0;
        end else begin
            if (op_valid) begin
                opv_seen++;
                if (qa.size() == 0) begin
                    chk("op_valid_unexpected", op_valid, 0);
                end else begin
                    m_a = qa.pop_front(); m_b = qb.pop_front(); m_o = qo.pop_front();
                end
            end
            chk("A", A, m_a);
            chk("B", B, m_b);
            chk("opcode", opcode, m_o);
            if (tx_start) begin
                if (qt.size() == 0) begin
                    chk("tx_start_unexpected", tx_start, 0);
                end else begin
                    cur_byte = qt.pop_front();
                    chk("d_out", d_out, cur_byte);
                    tx_log.push_back(d_out);
                    tx_busy = 1;
                end
            end else if (tx_busy) begin
                chk("d_out_stable", d_out, cur_byte);
            end
            if (tx_done) tx_busy = 0;
            if (err) err_seen++;
        end
    end

    initial begin
        reset = 1'b1; rx_done = 1'b0; d_in = 8'h00;
        repeat (3) step();
        check_zero("reset");
        reset = 1'b0;
        repeat (3) step();

        // basic frame and result transmission
        send_frame('{8'h05, 8'h04, 8'h20, 8'h2B, 8'h07, 8'h20});
        wait_idle();
        chk("lit_A", A, 32'h0000_0504);
        chk("lit_opcode", opcode, 6'h2B);
        chk("lit_B", B, 32'h0000_0007);
        chk("lit_op_valid_count", opv_seen, 1);
        chk("lit_tx_count", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            chk("lit_tx0", tx_log[0], 8'h00);
            chk("lit_tx1", tx_log[1], 8'h00);
            chk("lit_tx2", tx_log[2], 8'h05);
            chk("lit_tx3", tx_log[3], 8'h0B);
        end

        // operand overflow keeps the last four bytes
        send_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h20, 8'h2A, 8'h01, 8'h20});
        wait_idle();
        chk("lit_A_overflow", A, 32'h0203_0405);

        // empty operand A
        send_frame('{8'h20, 8'h11, 8'h09, 8'h20});
        wait_idle();
        chk("lit_A_empty", A, 32'h0);
        chk("lit_opcode_11", opcode, 6'h11);

        // delimiter accepted as an opcode
        send_frame('{8'h03, 8'h20, 8'h20, 8'h04, 8'h20});
        wait_idle();
        chk("lit_opcode_delim", opcode, 6'h20);

        // inter-byte timeout
        send_byte(8'h05);
        repeat (1000) step();
        ea = 0; eb = 0; ph = 0; exp_err++;
        chk("lit_timeout_err", err_seen, 1);
        send_frame('{8'h06, 8'h20, 8'h01, 8'h05, 8'h20});
        wait_idle();
        chk("lit_A_after_timeout", A, 32'h6);
        chk("lit_B_after_timeout", B, 32'h5);

        // overrun during transmission
        send_frame('{8'h0A, 8'h20, 8'h02, 8'h0B});
        m_byte(8'h20);
        d_in = 8'h20; rx_done = 1'b1;
        repeat (2) step();
        rx_done = 1'b0;
        wait_tx_start();
        d_in = 8'h55; rx_done = 1'b1;
        repeat (3) step();
        rx_done = 1'b0;
        exp_err++;
        wait_idle();
        chk("lit_overrun_err", err_seen, 2);
        chk("lit_tx_last", tx_log[tx_log.size()-1], 8'h15);

        // reset during transmission, rx_done held across reset release
        send_frame('{8'h01, 8'h20, 8'h07, 8'h01});
        m_byte(8'h20);
        d_in = 8'h20; rx_done = 1'b1;
        repeat (2) step();
        rx_done = 1'b0;
        wait_tx_start();
        reset = 1'b1; rx_done = 1'b1; d_in = 8'h99;
        step();
        check_zero("midtx_reset");
        qa.delete(); qb.delete(); qo.delete(); qt.delete();
        ea = 0; eb = 0; ph = 0;
        step();
        reset = 1'b0;
        repeat (10) step();
        rx_done = 1'b0;
        repeat (40) step();
        send_frame('{8'h01, 8'h20, 8'h0C, 8'h02, 8'h20});
        wait_idle();
        chk("lit_A_after_reset", A, 32'h1);
        chk("lit_B_after_reset", B, 32'h2);
        chk("lit_tx_after_reset", tx_log[tx_log.size()-1], 8'h03);

        chk("err_total", err_seen, exp_err);
        chk("pending_commits", qa.size(), 0);
        chk("pending_tx", qt.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
